// File: rtl/reward_scheduler.sv
`default_nettype none
// ============================================================================
// reward_scheduler - latches packet-send triggers, grants one by fixed
// priority, then sequences the reward packer and the radio TX handshake.
// Revision: 1.0
// ============================================================================
module reward_scheduler #(
    parameter int WORD_WIDTH   = 16,
    parameter int MR_TIMEOUT   = 15,
    parameter int CHT_TIMEOUT  = 15,
    parameter int DONE_TIMEOUT = 8,
    parameter int MAX_INV_HOPS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pkt_valid,
    input  logic [2:0]            fPacketType,
    input  logic                  iAmDestination,
    input  logic [WORD_WIDTH-1:0] hopsFromCH,
    input  logic                  role,
    input  logic                  low_E,
    input  logic                  iHaveData,
    input  logic                  cf_start,
    input  logic                  reward_done,
    input  logic                  tx_ack,
    output logic                  reward_en,
    output logic [2:0]            sel_type,
    output logic                  tx_req,
    output logic                  busy,
    output logic [5:0]            pending,
    output logic                  err_timeout
);

    localparam logic [2:0] c_type_hb   = 3'b000;
    localparam logic [2:0] c_type_inv  = 3'b010;
    localparam logic [2:0] c_type_mr   = 3'b011;
    localparam logic [2:0] c_type_cht  = 3'b100;
    localparam logic [2:0] c_type_data = 3'b101;
    localparam logic [2:0] c_type_sos  = 3'b110;
    localparam logic [2:0] c_type_none = 3'b111;

    localparam int c_bit_hb   = 0;
    localparam int c_bit_inv  = 1;
    localparam int c_bit_mr   = 2;
    localparam int c_bit_cht  = 3;
    localparam int c_bit_data = 4;
    localparam int c_bit_sos  = 5;

    localparam int c_wait_w = $clog2(DONE_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_ARB       = 3'd1,
        S_PACK      = 3'd2,
        S_WAIT_DONE = 3'd3,
        S_SEND      = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [5:0]            r_pend;
    logic [5:0]            w_set;
    logic [5:0]            w_clr;
    logic                  r_hb_lock;
    logic                  r_have_d;
    logic [WORD_WIDTH-1:0] r_tmr;
    logic                  r_tmr_run;
    logic                  r_tmr_role;
    logic                  w_tmr_fire;
    logic [c_wait_w-1:0]   r_wait;
    logic [c_wait_w-1:0]   w_wait_next;
    logic [2:0]            r_sel;
    logic [2:0]            w_sel_next;
    logic [5:0]            w_grant;
    logic [2:0]            w_grant_type;
    logic                  w_pkt_hb;
    logic                  w_pkt_data;
    logic                  w_fwd;
    logic                  w_own;

    // ---------------- event capture ----------------
    assign w_pkt_hb   = pkt_valid && (fPacketType == c_type_hb);
    assign w_pkt_data = pkt_valid && (fPacketType == c_type_data);
    assign w_fwd      = pkt_valid && iAmDestination &&
                        ((fPacketType == c_type_data) || (fPacketType == c_type_sos));
    assign w_own      = iHaveData && !r_have_d;
    // cf_start reloads the timer, so it suppresses a coincident expiry
    assign w_tmr_fire = r_tmr_run && !cf_start && (r_tmr <= WORD_WIDTH'(1));

    always_comb begin
        w_set             = '0;
        w_set[c_bit_hb]   = w_pkt_hb && !r_hb_lock;
        w_set[c_bit_inv]  = pkt_valid && (fPacketType == c_type_inv) &&
                            (hopsFromCH < WORD_WIDTH'(MAX_INV_HOPS));
        w_set[c_bit_mr]   = w_tmr_fire && !r_tmr_role;
        w_set[c_bit_cht]  = w_tmr_fire && r_tmr_role;
        w_set[c_bit_data] = (w_fwd && (fPacketType == c_type_data) && !low_E) ||
                            (w_own && !low_E);
        w_set[c_bit_sos]  = (w_fwd && ((fPacketType == c_type_sos) || low_E)) ||
                            (w_own && low_E);
    end

    // ---------------- fixed-priority grant ----------------
    always_comb begin
        w_grant      = '0;
        w_grant_type = c_type_none;
        if (r_pend[c_bit_sos]) begin
            w_grant[c_bit_sos] = 1'b1;
            w_grant_type       = c_type_sos;
        end else if (r_pend[c_bit_data]) begin
            w_grant[c_bit_data] = 1'b1;
            w_grant_type        = c_type_data;
        end else if (r_pend[c_bit_cht]) begin
            w_grant[c_bit_cht] = 1'b1;
            w_grant_type       = c_type_cht;
        end else if (r_pend[c_bit_mr]) begin
            w_grant[c_bit_mr] = 1'b1;
            w_grant_type      = c_type_mr;
        end else if (r_pend[c_bit_inv]) begin
            w_grant[c_bit_inv] = 1'b1;
            w_grant_type       = c_type_inv;
        end else if (r_pend[c_bit_hb]) begin
            w_grant[c_bit_hb] = 1'b1;
            w_grant_type      = c_type_hb;
        end
    end

    assign w_clr = (r_state == S_ARB) ? w_grant : 6'b0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pend     <= '0;
            r_hb_lock  <= 1'b0;
            r_have_d   <= 1'b0;
            r_tmr      <= '0;
            r_tmr_run  <= 1'b0;
            r_tmr_role <= 1'b0;
        end else begin
            // set wins over a same-cycle grant clear
            r_pend   <= (r_pend & ~w_clr) | w_set;
            r_have_d <= iHaveData;
            if (w_pkt_data) begin
                r_hb_lock <= 1'b0;
            end else if (w_pkt_hb) begin
                r_hb_lock <= 1'b1;
            end
            if (cf_start) begin
                r_tmr      <= role ? WORD_WIDTH'(CHT_TIMEOUT) : WORD_WIDTH'(MR_TIMEOUT);
                r_tmr_run  <= 1'b1;
                r_tmr_role <= role;
            end else if (w_tmr_fire) begin
                r_tmr     <= '0;
                r_tmr_run <= 1'b0;
            end else if (r_tmr_run) begin
                r_tmr <= r_tmr - WORD_WIDTH'(1);
            end
        end
    end

    // ---------------- sequencing FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_sel   <= c_type_none;
            r_wait  <= '0;
        end else begin
            r_state <= w_state_next;
            r_sel   <= w_sel_next;
            r_wait  <= w_wait_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_sel_next   = r_sel;
        w_wait_next  = '0;
        reward_en    = 1'b0;
        tx_req       = 1'b0;
        err_timeout  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_pend != 6'b0) begin
                    w_state_next = S_ARB;
                end
            end
            S_ARB: begin
                w_sel_next   = w_grant_type;
                w_state_next = (r_pend != 6'b0) ? S_PACK : S_IDLE;
            end
            S_PACK: begin
                reward_en    = 1'b1;
                w_state_next = S_WAIT_DONE;
            end
            S_WAIT_DONE: begin
                if (reward_done) begin
                    w_state_next = S_SEND;
                end else if (r_wait == c_wait_w'(DONE_TIMEOUT - 1)) begin
                    err_timeout  = 1'b1;
                    w_sel_next   = c_type_none;
                    w_state_next = S_IDLE;
                end else begin
                    w_wait_next = r_wait + c_wait_w'(1);
                end
            end
            S_SEND: begin
                tx_req = 1'b1;
                if (tx_ack) begin
                    w_sel_next   = c_type_none;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_sel_next   = c_type_none;
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign sel_type = r_sel;
    assign busy     = (r_state != S_IDLE);
    assign pending  = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_reward_scheduler.sv
`default_nettype none
// ============================================================================
// tb_reward_scheduler - directed vectors with hand-computed expectations.
// Revision: 1.0
// ============================================================================
module tb_reward_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pkt_valid = 1'b0;
    logic [2:0]  fPacketType = 3'b000;
    logic        iAmDestination = 1'b0;
    logic [15:0] hopsFromCH = 16'd0;
    logic        role = 1'b0;
    logic        low_E = 1'b0;
    logic        iHaveData = 1'b0;
    logic        cf_start = 1'b0;
    logic        reward_done = 1'b0;
    logic        tx_ack = 1'b0;
    logic        reward_en;
    logic [2:0]  sel_type;
    logic        tx_req;
    logic        busy;
    logic [5:0]  pending;
    logic        err_timeout;

    int n_total = 0;
    int n_bad   = 0;

    reward_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .pkt_valid      (pkt_valid),
        .fPacketType    (fPacketType),
        .iAmDestination (iAmDestination),
        .hopsFromCH     (hopsFromCH),
        .role           (role),
        .low_E          (low_E),
        .iHaveData      (iHaveData),
        .cf_start       (cf_start),
        .reward_done    (reward_done),
        .tx_ack         (tx_ack),
        .reward_en      (reward_en),
        .sel_type       (sel_type),
        .tx_req         (tx_req),
        .busy           (busy),
        .pending        (pending),
        .err_timeout    (err_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_pkt(input logic [2:0] t, input logic [15:0] hops, input logic dest);
        pkt_valid      = 1'b1;
        fPacketType    = t;
        hopsFromCH     = hops;
        iAmDestination = dest;
        tick();
        pkt_valid      = 1'b0;
        iAmDestination = 1'b0;
    endtask

    task automatic wait_en();
        int n = 0;
        while (!reward_en && n < 20) begin
            tick();
            n++;
        end
        check("reward_en_seen", reward_en, 1);
    endtask

    // full grant: reward_en -> reward_done -> tx_req -> tx_ack
    task automatic serve(input logic [2:0] exp_type);
        wait_en();
        check("sel_at_en", sel_type, exp_type);
        tick();
        reward_done = 1'b1;
        tick();
        reward_done = 1'b0;
        check("tx_req_high", tx_req, 1);
        check("sel_in_send", sel_type, exp_type);
        tx_ack = 1'b1;
        tick();
        tx_ack = 1'b0;
        check("tx_req_low", tx_req, 0);
        check("sel_after_ack", sel_type, 3'b111);
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_reward_en", reward_en, 0);
        check("rst_sel", sel_type, 3'b111);
        check("rst_tx_req", tx_req, 0);
        check("rst_busy", busy, 0);
        check("rst_pending", pending, 0);
        check("rst_err", err_timeout, 0);
        rst = 1'b0;
        tick();

        // HB twice: only one grant while locked
        send_pkt(3'b000, 16'd0, 1'b0);
        check("hb_pend", pending, 6'b000001);
        send_pkt(3'b000, 16'd0, 1'b0);
        serve(3'b000);
        check("hb_no_second", pending, 6'b000000);
        tick();
        tick();
        check("hb_idle", busy, 0);

        // Data rx unlocks HB
        send_pkt(3'b101, 16'd0, 1'b0);
        check("data_nodest_pend", pending, 6'b000000);
        send_pkt(3'b000, 16'd0, 1'b0);
        check("hb_relock_pend", pending, 6'b000001);
        serve(3'b000);

        // INV hop threshold
        send_pkt(3'b010, 16'd3, 1'b0);
        check("inv3_pend", pending, 6'b000010);
        serve(3'b010);
        send_pkt(3'b010, 16'd4, 1'b0);
        check("inv4_ignored", pending, 6'b000000);

        // forwarded Data addressed to us
        send_pkt(3'b101, 16'd0, 1'b1);
        check("data_dest_pend", pending, 6'b010000);
        serve(3'b101);

        // MR timer: pend exactly 15 cycles after cf_start
        role     = 1'b0;
        cf_start = 1'b1;
        tick();
        cf_start = 1'b0;
        for (int i = 1; i < 15; i++) tick();
        check("mr_not_yet", pending, 6'b000000);
        tick();
        check("mr_pend", pending, 6'b000100);
        tick();
        check("mr_arb_no_en", reward_en, 0);
        tick();
        check("mr_en_2cyc", reward_en, 1);
        serve(3'b011);

        // priority SOS > INV > HB
        send_pkt(3'b101, 16'd0, 1'b0);
        low_E     = 1'b1;
        iHaveData = 1'b1;
        send_pkt(3'b000, 16'd0, 1'b0);
        send_pkt(3'b010, 16'd1, 1'b0);
        check("prio_pend", pending, 6'b100011);
        serve(3'b110);
        serve(3'b010);
        serve(3'b000);
        iHaveData = 1'b0;
        low_E     = 1'b0;
        tick();

        // watchdog: reward_done during PACK is ignored, then no done
        send_pkt(3'b010, 16'd0, 1'b0);
        wait_en();
        reward_done = 1'b1;
        tick();
        reward_done = 1'b0;
        for (int k = 0; k < 7; k++) begin
            check("wd_no_err", err_timeout, 0);
            tick();
        end
        check("wd_err", err_timeout, 1);
        check("wd_busy", busy, 1);
        tick();
        check("wd_err_pulse", err_timeout, 0);
        check("wd_idle", busy, 0);
        check("wd_sel", sel_type, 3'b111);
        check("wd_not_requeued", pending, 6'b000000);

        // async reset during SEND
        send_pkt(3'b010, 16'd0, 1'b0);
        wait_en();
        tick();
        reward_done = 1'b1;
        tick();
        reward_done = 1'b0;
        check("rs_tx_req", tx_req, 1);
        send_pkt(3'b010, 16'd2, 1'b0);
        check("rs_pend", pending, 6'b000010);
        #2;
        rst = 1'b1;
        #1;
        check("rs_tx_req_clr", tx_req, 0);
        check("rs_pend_clr", pending, 6'b000000);
        check("rs_sel", sel_type, 3'b111);
        check("rs_busy", busy, 0);
        tick();
        rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
